// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side instruction port.
// The fetch stage connects through the master modport; memory and decode use slave.
interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [14:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [18:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [18:0] instruction;
   logic [18:0] pc;
   logic        branch_taken;
   logic [18:0] next_pc;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instruction, pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, branch_taken, next_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instruction, pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, branch_taken, next_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited in-order prefetch into a small FIFO, with branch redirect.
// Define FETCH_BYPASS_EN to forward a response straight to the outputs while the FIFO is empty.
module instr_fetch #(
   parameter logic [14:0] RESET_PC  = 15'h0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);
   localparam int unsigned PtrW = $clog2(BUF_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned SumW = CntW + 1;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e          state_q, state_d;
   logic [14:0]     fetch_pc_q, fetch_pc_d;
   logic [CntW-1:0] inflight_q, inflight_d;
   logic [CntW-1:0] drop_q, drop_d;
   logic [CntW-1:0] occ_q, occ_d;
   logic            pend_q, pend_d;
   logic            stale_q, stale_d;
   logic [14:0]     pend_addr_q;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [18:0]     buf_data_q [BUF_DEPTH];
   logic [14:0]     buf_addr_q [BUF_DEPTH];

   logic            head_valid, redirect, pop, fifo_pop, push;
   logic            rsp_keep, rsp_drop, new_req, hs, credit_ok;
   logic [14:0]     rsp_addr;
   logic [SumW-1:0] credit_used, outstanding;
   logic            unused_np;

   assign unused_np  = ^bus.next_pc[18:15];
   assign head_valid = (occ_q != '0);
   // Kept requests are consecutive, so the oldest one sits inflight words behind fetch_pc.
   assign rsp_addr   = fetch_pc_q - 15'(inflight_q);
   assign rsp_keep   = bus.imem_rsp_valid && (drop_q == '0);
   assign rsp_drop   = bus.imem_rsp_valid && (drop_q != '0);
   assign pop        = bus.instr_valid && bus.instr_ready;
   assign redirect   = pop && bus.branch_taken;
   assign fifo_pop   = head_valid && bus.instr_ready && !redirect;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass          = !head_valid && rsp_keep;
   assign bus.instr_valid = head_valid || bypass;
   assign bus.instruction = head_valid ? buf_data_q[rd_ptr_q] : (bypass ? bus.imem_rsp_data : '0);
   assign bus.pc          = {4'b0, head_valid ? buf_addr_q[rd_ptr_q] : (bypass ? rsp_addr : '0)};
   assign push            = rsp_keep && !redirect && !(bypass && bus.instr_ready);
`else
   assign bus.instr_valid = head_valid;
   assign bus.instruction = head_valid ? buf_data_q[rd_ptr_q] : '0;
   assign bus.pc          = {4'b0, head_valid ? buf_addr_q[rd_ptr_q] : 15'h0};
   assign push            = rsp_keep && !redirect;
`endif

   // A word consumed this cycle frees its credit immediately to sustain one fetch per cycle.
   assign credit_used = SumW'(inflight_q) + SumW'(occ_q) - SumW'(pop);
   assign credit_ok   = credit_used < SumW'(BUF_DEPTH);
   assign new_req     = (state_q == StFetch) && !pend_q && credit_ok && !redirect;

   assign bus.imem_req_valid = pend_q || new_req;
   assign bus.imem_req_addr  = pend_q ? pend_addr_q : fetch_pc_q;
   assign hs                 = bus.imem_req_valid && bus.imem_req_ready;
   assign outstanding = SumW'(drop_q) + SumW'(inflight_q) + SumW'(hs) - SumW'(bus.imem_rsp_valid);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = bus.imem_req_valid && !bus.imem_req_ready;
      stale_d    = stale_q && !hs;
      inflight_d = inflight_q + CntW'(hs && !stale_q) - CntW'(rsp_keep);
      drop_d     = drop_q + CntW'(hs && stale_q) - CntW'(rsp_drop);
      occ_d      = occ_q + CntW'(push) - CntW'(fifo_pop);
      if (hs && !stale_q) begin
         fetch_pc_d = fetch_pc_q + 15'd1;
      end
      if (redirect) begin
         // A request still waiting for acceptance becomes stale and is dropped once accepted.
         fetch_pc_d = bus.next_pc[14:0];
         inflight_d = '0;
         drop_d     = CntW'(outstanding);
         stale_d    = pend_d;
         occ_d      = '0;
      end
      unique case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: if (redirect && ((outstanding != '0) || pend_d)) state_d = StDrain;
         StDrain: if ((drop_q == '0) && !stale_q) state_d = StFetch;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         fetch_pc_q  <= RESET_PC;
         inflight_q  <= '0;
         drop_q      <= '0;
         occ_q       <= '0;
         pend_q      <= 1'b0;
         stale_q     <= 1'b0;
         pend_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         occ_q       <= occ_d;
         pend_q      <= pend_d;
         stale_q     <= stale_d;
         pend_addr_q <= bus.imem_req_addr;
         if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= bus.imem_rsp_data;
         buf_addr_q[wr_ptr_q] <= rsp_addr;
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      !(push && (occ_q == CntW'(BUF_DEPTH)) && !fifo_pop));
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-1 memory that returns {4'h5, addr}.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst;
   int          tests = 0;
   int          fails = 0;
   logic        s_rst, s_ir, s_rr, s_bt;
   logic [18:0] s_np;
   logic        mem_hs;
   logic [14:0] mem_addr;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(15'h0010), .BUF_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #2;
         mem_hs   = bus.imem_req_valid && bus.imem_req_ready;
         mem_addr = bus.imem_req_addr;
         @(posedge clk);
         #1;
         bus.imem_rsp_valid = mem_hs;
         bus.imem_rsp_data  = {4'h5, mem_addr};
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic go();
      @(negedge clk);
      rst                = s_rst;
      bus.instr_ready    = s_ir;
      bus.imem_req_ready = s_rr;
      bus.branch_taken   = s_bt;
      bus.next_pc        = s_np;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic ev, input logic [14:0] ea);
      chk({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'(ev));
      if (ev) chk({tag, " req_addr"}, 32'(bus.imem_req_addr), 32'(ea));
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [14:0] ea);
      chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(ev));
      if (ev) begin
         chk({tag, " pc"}, 32'(bus.pc), 32'({4'h0, ea}));
         chk({tag, " instruction"}, 32'(bus.instruction), 32'({4'h5, ea}));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'd0);
      chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, " instruction"}, 32'(bus.instruction), 32'd0);
      chk({tag, " pc"}, 32'(bus.pc), 32'd0);
   endtask

   initial begin
      s_rst = 1'b1; s_ir = 1'b1; s_rr = 1'b1; s_bt = 1'b0; s_np = 19'h12345;
      rst = 1'b1;
      bus.instr_ready = 1'b1; bus.imem_req_ready = 1'b1;
      bus.branch_taken = 1'b0; bus.next_pc = s_np;
      go(); go();
      chk_zero("reset");

      // Streaming from RESET_PC; next_pc is junk while branch_taken is low.
      s_rst = 1'b0; go(); chk_req("c0", 1'b0, 15'h0);
      go(); chk_req("c1", 1'b1, 15'h0010);
      go(); chk_req("c2", 1'b1, 15'h0011); chk_out("c2", 1'b0, 15'h0);
      go(); chk_req("c3", 1'b1, 15'h0012); chk_out("c3", 1'b1, 15'h0010);
      go(); chk_out("c4", 1'b1, 15'h0011);

      // Decode stall: credit exhausted, head word holds.
      s_ir = 1'b0; go(); chk_req("stall0", 1'b0, 15'h0); chk_out("stall0", 1'b1, 15'h0012);
      go(); chk_req("stall1", 1'b0, 15'h0); chk_out("stall1", 1'b1, 15'h0012);
      go(); chk_out("stall2", 1'b1, 15'h0012);
      s_ir = 1'b1; go(); chk_req("resume0", 1'b1, 15'h0014); chk_out("resume0", 1'b1, 15'h0012);
      go(); chk_req("resume1", 1'b1, 15'h0015); chk_out("resume1", 1'b1, 15'h0013);

      // Redirect with upper next_pc bits set; held branch_taken ignored while nothing valid.
      s_bt = 1'b1; s_np = 19'h7ABCD; go();
      chk_req("br_r", 1'b0, 15'h0); chk_out("br_r", 1'b1, 15'h0014);
      s_np = 19'h01111; go(); chk_req("br_r1", 1'b1, 15'h2BCD); chk_out("br_r1", 1'b0, 15'h0);
      go(); chk_req("br_r2", 1'b1, 15'h2BCE); chk_out("br_r2", 1'b0, 15'h0);

      // Redirect to the top of the address space to observe the wrap.
      s_np = 19'h07FFF; go(); chk_out("br_r3", 1'b1, 15'h2BCD);
      s_bt = 1'b0; go(); chk_req("wrap0", 1'b1, 15'h7FFF); chk_out("wrap0", 1'b0, 15'h0);
      go(); chk_req("wrap1", 1'b1, 15'h0000);
      go(); chk_out("wrap2", 1'b1, 15'h7FFF);
      go(); chk_out("wrap3", 1'b1, 15'h0000); chk_req("wrap3", 1'b1, 15'h0002);

      // Memory refuses requests across a redirect: pending address must hold and be dropped.
      s_rr = 1'b0; go(); chk_req("rdy0", 1'b1, 15'h0003); chk_out("rdy0", 1'b1, 15'h0001);
      s_bt = 1'b1; s_np = 19'h00100; go();
      chk_req("rdy1", 1'b1, 15'h0003); chk_out("rdy1", 1'b1, 15'h0002);
      s_bt = 1'b0; go(); chk_req("rdy2", 1'b1, 15'h0003); chk_out("rdy2", 1'b0, 15'h0);
      go(); chk_req("rdy3", 1'b1, 15'h0003);
      go(); chk_req("rdy4", 1'b1, 15'h0003);
      s_rr = 1'b1; go(); chk_req("rdy5", 1'b1, 15'h0003);
      go(); chk_req("drain0", 1'b0, 15'h0); chk_out("drain0", 1'b0, 15'h0);
      go(); chk_req("drain1", 1'b0, 15'h0);
      go(); chk_req("tgt0", 1'b1, 15'h0100);
      go(); chk_out("tgt1", 1'b0, 15'h0);
      go(); chk_out("tgt2", 1'b1, 15'h0100);

      // Reset while draining.
      s_rr = 1'b0; go(); chk_req("pre_rst0", 1'b1, 15'h0103);
      s_bt = 1'b1; s_np = 19'h00200; go(); chk_out("pre_rst1", 1'b1, 15'h0102);
      s_bt = 1'b0; s_rst = 1'b1; go(); chk_req("pre_rst2", 1'b1, 15'h0103);
      go(); chk_zero("rst_drain");

      // Restart with decode stalled: exactly two requests, then the head holds.
      s_rst = 1'b0; s_rr = 1'b1; s_ir = 1'b0; go(); chk_req("re0", 1'b0, 15'h0);
      go(); chk_req("re1", 1'b1, 15'h0010);
      go(); chk_req("re2", 1'b1, 15'h0011);
      go(); chk_req("re3", 1'b0, 15'h0); chk_out("re3", 1'b1, 15'h0010);
      go(); chk_req("re4", 1'b0, 15'h0); chk_out("re4", 1'b1, 15'h0010);
      s_ir = 1'b1; go(); chk_req("re5", 1'b1, 15'h0012); chk_out("re5", 1'b1, 15'h0010);
      go(); chk_out("re6", 1'b1, 15'h0011);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
